// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a host FSM, the counter_sequencer and its counter.
// Latency: n/a (wires only); the counter's count output rides in count_in.
// Backpressure: none; start is a level request, honoured only while the sequencer is idle.
// Build option: COUNTER_SEQ_CHECK_EN adds the seq_error status bit.
// Ports (master = host/counter side drives, slave = sequencer drives):
//   start, abort, terminal, periods, count_in          -> into the sequencer
//   counter_clear, busy, period_tick, done, periods_done -> out of the sequencer
interface counter_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  terminal;
    logic [PCNT_W-1:0] periods;
    logic [WIDTH-1:0]  count_in;
    logic              counter_clear;
    logic              busy;
    logic              period_tick;
    logic              done;
    logic [PCNT_W-1:0] periods_done;
`ifdef COUNTER_SEQ_CHECK_EN
    logic              seq_error;
`endif

    modport master (
        output start, abort, terminal, periods, count_in,
        input  counter_clear, busy, period_tick, done, periods_done
`ifdef COUNTER_SEQ_CHECK_EN
        , input seq_error
`endif
    );

    modport slave (
        input  start, abort, terminal, periods, count_in,
        output counter_clear, busy, period_tick, done, periods_done
`ifdef COUNTER_SEQ_CHECK_EN
        , output seq_error
`endif
    );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for a free-running counter: holds it at 0 when idle, wraps it at terminal for N periods.
// Latency: first period_tick after terminal RUN cycles; done one cycle after the final wrap.
// Backpressure: none; start is ignored outside IDLE, abort ends a run in the same cycle.
// Ports: clock, clear (sync, active-high), ctl (counter_sequencer_if.slave) carrying the
//   start/abort/terminal/periods request, the counter's count_in, and the counter_clear,
//   busy, period_tick, done, periods_done status.
// Build option: COUNTER_SEQ_CHECK_EN adds a shadow counter and a sticky ctl.seq_error.
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic                clock,
    input  logic                clear,
    counter_sequencer_if.slave  ctl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  terminal_q;
    logic [WIDTH-1:0]  term_m1;
    logic [PCNT_W-1:0] periods_q;
    logic [PCNT_W-1:0] periods_done_q;
    logic              wrap;
    logic              accept;
    logic              last_period;
    logic              clr;
    logic              busy;
    logic              tick;
    logic              done;

    // terminal 0 wraps at all ones, giving a full 2^WIDTH period.
    assign term_m1 = terminal_q - WIDTH'(1);
    assign wrap    = (state_q == S_RUN) && (ctl.count_in == term_m1);
    assign accept  = (state_q == S_IDLE) && ctl.start && !ctl.abort;

    // Extra bit keeps a saturated periods_done from aliasing onto periods_q.
    assign last_period = (periods_q != '0) &&
                         (({1'b0, periods_done_q} + (PCNT_W+1)'(1)) == {1'b0, periods_q});

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        busy    = 1'b0;
        tick    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr = 1'b1;
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (ctl.abort) begin
                    // Abort wins over a coincident wrap: no tick, no count.
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else if (wrap) begin
                    clr  = 1'b1;
                    tick = 1'b1;
                    if (last_period) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                clr     = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                clr     = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        // Counter is held at zero for as long as clear is asserted.
        if (clear) begin
            clr = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            terminal_q     <= '0;
            periods_q      <= '0;
            periods_done_q <= '0;
        end else if (accept) begin
            terminal_q     <= ctl.terminal;
            periods_q      <= ctl.periods;
            periods_done_q <= '0;
        end else if (wrap && !ctl.abort && (periods_done_q != '1)) begin
            periods_done_q <= periods_done_q + PCNT_W'(1);
        end
    end

    assign ctl.counter_clear = clr;
    assign ctl.busy          = busy;
    assign ctl.period_tick   = tick;
    assign ctl.done          = done;
    assign ctl.periods_done  = periods_done_q;

`ifdef COUNTER_SEQ_CHECK_EN
    // Shadow copy of what the counter should read, advanced by the same wrap rule.
    logic [WIDTH-1:0] shadow_q;
    logic             seq_error_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            shadow_q    <= '0;
            seq_error_q <= 1'b0;
        end else if (accept) begin
            shadow_q    <= '0;
            seq_error_q <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (ctl.count_in != shadow_q) begin
                seq_error_q <= 1'b1;
            end
            shadow_q <= (shadow_q == term_m1) ? '0 : shadow_q + WIDTH'(1);
        end else begin
            shadow_q <= '0;
        end
    end

    assign ctl.seq_error = seq_error_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomised scoreboard bench for counter_sequencer with an attached counter model.
// Latency: expected tick/done cycles come from the period arithmetic, not the RTL.
// Backpressure: none; the monitor pops one expected event per observed tick or done.
module tb_counter_sequencer;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;
    localparam int FULL   = 1 << WIDTH;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    counter_sequencer_if #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) bus ();

    counter_sequencer #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .ctl   (bus)
    );

    // Attached free-running counter, with an override for fault injection.
    logic [WIDTH-1:0] cnt;
    logic             inj;
    logic [WIDTH-1:0] inj_val;
    always @(posedge clock) cnt <= bus.counter_clear ? '0 : cnt + 1'b1;
    assign bus.count_in = inj ? inj_val : cnt;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit is_done;
        int at;
        int pd;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    bit  mon_en = 1'b0;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(negedge clock) begin
        if (mon_en && (bus.period_tick || bus.done)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event at cyc %0d: tick=%0b done=%0b required=no event",
                         cyc, bus.period_tick, bus.done);
            end else begin
                ev = exp_q.pop_front();
                chk("event_kind", int'(bus.done), int'(ev.is_done));
                chk("event_cycle", cyc, ev.at);
                chk("event_periods_done", int'(bus.periods_done), ev.pd);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One run from IDLE: abort_at = RUN cycle carrying abort (0 = none).
    task automatic do_run(input int term, input int per, input int abort_at);
        int teff;
        int endr;
        int c;
        int nticks;
        teff = (term == 0) ? FULL : term;
        endr = (abort_at != 0) ? abort_at : per * teff;
        bus.terminal = term[WIDTH-1:0];
        bus.periods  = per[PCNT_W-1:0];
        bus.start    = 1'b1;
        c = cyc;
        // A period ends on RUN cycle k*teff; an aborting cycle never ticks.
        nticks = (abort_at != 0) ? (endr - 1) / teff : per;
        for (int k = 1; k <= nticks; k++) begin
            exp_q.push_back('{is_done: 1'b0, at: c + k * teff, pd: sat(k - 1)});
        end
        if (abort_at == 0) begin
            exp_q.push_back('{is_done: 1'b1, at: c + endr + 1, pd: sat(per)});
        end
        for (int r = 1; r <= endr; r++) begin
            step();
            // Mid-run activity on start/terminal/periods must be ignored.
            bus.start    = (r < endr) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.terminal = WIDTH'($urandom);
            bus.periods  = PCNT_W'($urandom);
            bus.abort    = (r == abort_at);
            if (r == 1) chk("busy_in_run", int'(bus.busy), 1);
            if (r == abort_at) begin
                #1;
                chk("abort_counter_clear", int'(bus.counter_clear), 1);
                chk("abort_no_tick", int'(bus.period_tick), 0);
            end
        end
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (abort_at == 0) begin
            chk("done_cycle_busy", int'(bus.busy), 0);
            chk("done_cycle_counter_clear", int'(bus.counter_clear), 1);
            step();
            chk("idle_periods_done", int'(bus.periods_done), sat(per));
        end else begin
            chk("abort_periods_done", int'(bus.periods_done), sat(nticks));
        end
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_count_held", int'(bus.count_in), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;
        int p;
        int tot;
        int a;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.terminal = '0;
        bus.periods = '0;
        inj         = 1'b0;
        inj_val     = '0;
        step();
        chk("clear_counter_clear", int'(bus.counter_clear), 1);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_counter_clear", int'(bus.counter_clear), 1);
            chk("reset_count_in", int'(bus.count_in), 0);
            chk("reset_busy", int'(bus.busy), 0);
            chk("reset_done", int'(bus.done), 0);
            chk("reset_tick", int'(bus.period_tick), 0);
            chk("reset_periods_done", int'(bus.periods_done), 0);
        end
        mon_en = 1'b1;

        do_run(10, 2, 0);
        do_run(0, 0, 41);
        do_run(1, 3, 0);

        // start together with abort in IDLE must not launch a run.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle_busy", int'(bus.busy), 0);
        chk("start_abort_idle_clear", int'(bus.counter_clear), 1);

        // Saturation of periods_done in a continuous single-cycle-period run.
        do_run(1, 0, 300);

        // Synchronous clear in the second period at count 6.
        bus.terminal = 4'd10;
        bus.periods  = 8'd5;
        bus.start    = 1'b1;
        c = cyc;
        exp_q.push_back('{is_done: 1'b0, at: c + 10, pd: 0});
        step();
        bus.start = 1'b0;
        while (cyc < c + 17) step();
        chk("clear_mid_run_count", int'(bus.count_in), 6);
        clear = 1'b1;
        #1;
        chk("clear_mid_run_counter_clear", int'(bus.counter_clear), 1);
        step();
        clear = 1'b0;
        chk("after_clear_busy", int'(bus.busy), 0);
        chk("after_clear_counter_clear", int'(bus.counter_clear), 1);
        chk("after_clear_periods_done", int'(bus.periods_done), 0);
        chk("after_clear_count_in", int'(bus.count_in), 0);
        step();
        do_run(3, 2, 0);

`ifdef COUNTER_SEQ_CHECK_EN
        // Corrupt count_in on RUN cycle 4 (shadow reads 3 there).
        bus.terminal = 4'd10;
        bus.periods  = 8'd0;
        bus.start    = 1'b1;
        c = cyc;
        step();
        bus.start = 1'b0;
        chk("seq_error_clean_start", int'(bus.seq_error), 0);
        while (cyc < c + 4) step();
        inj_val = 4'd7;
        inj     = 1'b1;
        step();
        inj = 1'b0;
        chk("seq_error_set", int'(bus.seq_error), 1);
        step();
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("seq_error_sticky", int'(bus.seq_error), 1);
        do_run(3, 1, 0);
        chk("seq_error_cleared_by_start", int'(bus.seq_error), 0);
`endif

        for (int n = 0; n < 12; n++) begin
            t   = $urandom_range(0, 15);
            p   = $urandom_range(1, 3);
            tot = p * ((t == 0) ? FULL : t);
            a   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tot) : 0;
            do_run(t, p, a);
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end

        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
